// File: rtl/daq_pkg.sv
// Shared trailer markers and sequencer state encoding
// for the DAQ frame builder.
package daq_pkg;

  localparam logic [3:0]  TRL_L1A_MK = 4'hA;
  localparam logic [3:0]  TRL_SMP_MK = 4'hB;
  localparam logic [15:0] TRL_END    = 16'h7FFF;
  localparam logic [15:0] TRL_NXT    = 16'h7FFE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TRL,
    ST_GAP
  } state_e;

endpackage

// File: rtl/daq_frame_builder_if.sv
// Frame builder bus: L1A input, sample FIFO side
// and channel-link output side.
interface daq_frame_builder_if;

  logic        L1A_MATCH_IN;
  logic [11:0] L1A_NUM;
  logic        SMP_EMPTY;
  logic [15:0] SMP_DATA;
  logic        SMP_RD;
  logic [15:0] FRAME_DATA;
  logic        DVALID;
  logic        LAST_WRD;
  logic        L1A_MATCH;
  logic        OVLP_MUX;
  logic        MLT_OVLP;
  logic        Q_OVF;

  modport master (
    output L1A_MATCH_IN, L1A_NUM,
    output SMP_EMPTY, SMP_DATA,
    input  SMP_RD, FRAME_DATA, DVALID,
    input  LAST_WRD, L1A_MATCH,
    input  OVLP_MUX, MLT_OVLP, Q_OVF
  );

  modport slave (
    input  L1A_MATCH_IN, L1A_NUM,
    input  SMP_EMPTY, SMP_DATA,
    output SMP_RD, FRAME_DATA, DVALID,
    output LAST_WRD, L1A_MATCH,
    output OVLP_MUX, MLT_OVLP, Q_OVF
  );

endinterface

// File: rtl/l1a_num_fifo.sv
// Synchronous QDEPTH x 12 queue of pending L1A numbers.
// Pushes while full are ignored; the caller flags them.
module l1a_num_fifo #(
  parameter  int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [11:0]   i_din,
  input  logic          i_pop,
  output logic [11:0]   o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_cnt
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [11:0]   r_mem [QDEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(QDEPTH));
  assign o_cnt   = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/daq_frame_builder.sv
// Readout sequencer: per queued L1A, NSAMP blocks of
// NWORDS ADC words, each followed by 4 trailer words.
module daq_frame_builder
  import daq_pkg::*;
#(
  parameter int NSAMP  = 8,
  parameter int NWORDS = 96,
  parameter int QDEPTH = 4
) (
  input logic CLK,
  input logic RST,
  daq_frame_builder_if.slave bus
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [6:0]    W_LAST = 7'(NWORDS - 1);
  localparam logic [2:0]    S_LAST = 3'(NSAMP - 1);
  localparam logic [CW-1:0] OCC2   = CW'(2);

  state_e        r_state;
  logic [6:0]    r_word_cnt;
  logic [2:0]    r_smp_idx;
  logic [1:0]    r_trl_cnt;
  logic [11:0]   r_cur_l1a;
  logic [15:0]   r_xor;
  logic          r_s1_adc;
  logic          r_s1_trl;
  logic          r_s1_t0;
  logic          r_s1_last;
  logic [15:0]   r_s1_word;
  logic [15:0]   r_data;
  logic          r_dvalid;
  logic          r_last;
  logic          r_l1a_match;
  logic          r_ovlp;
  logic          r_mlt;
  logic          r_qovf;

  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_cnt;
  logic [11:0]   w_head;
  logic          w_pop;
  logic          w_rd;
  logic          w_push_ok;
  logic          w_last_smp;
  logic          w_blk_end;
  logic          w_xor_clr;

  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_rd       = (r_state == ST_DATA) && !bus.SMP_EMPTY;
  assign w_push_ok  = bus.L1A_MATCH_IN && !w_full;
  assign w_last_smp = (r_smp_idx == S_LAST);
  assign w_blk_end  = (r_state == ST_TRL) && (r_trl_cnt == 2'd3);
  assign w_xor_clr  = w_pop || (w_blk_end && !w_last_smp);

  l1a_num_fifo #(.QDEPTH(QDEPTH)) u_l1a_q (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (bus.L1A_MATCH_IN),
    .i_din   (bus.L1A_NUM),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_cnt   (w_cnt)
  );

  // Trailer words ride a one-cycle stage so they line up
  // behind ADC words, which wait a cycle for SMP_DATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= '0;
      r_smp_idx  <= '0;
      r_trl_cnt  <= '0;
      r_cur_l1a  <= '0;
      r_ovlp     <= 1'b0;
      r_s1_adc   <= 1'b0;
      r_s1_trl   <= 1'b0;
      r_s1_t0    <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_word  <= '0;
    end else begin
      r_s1_adc  <= w_rd;
      r_s1_trl  <= 1'b0;
      r_s1_t0   <= 1'b0;
      r_s1_last <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cur_l1a  <= w_head;
            r_ovlp     <= (w_cnt >= OCC2) || w_push_ok;
            r_smp_idx  <= '0;
            r_word_cnt <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_rd) begin
            if (r_word_cnt == W_LAST) begin
              r_trl_cnt <= '0;
              r_state   <= ST_TRL;
            end else begin
              r_word_cnt <= r_word_cnt + 7'd1;
            end
          end
        end
        ST_TRL: begin
          r_s1_trl  <= 1'b1;
          r_s1_t0   <= (r_trl_cnt == 2'd0);
          r_s1_last <= w_blk_end && w_last_smp;
          r_trl_cnt <= r_trl_cnt + 2'd1;
          unique case (1'b1)
            r_trl_cnt == 2'd1:
              r_s1_word <= {TRL_L1A_MK, r_cur_l1a};
            r_trl_cnt == 2'd2:
              r_s1_word <= {TRL_SMP_MK, 9'b0, r_smp_idx};
            r_trl_cnt == 2'd3:
              r_s1_word <= w_last_smp ? TRL_END : TRL_NXT;
            default:
              r_s1_word <= '0;
          endcase
          if (w_blk_end) begin
            if (w_last_smp) begin
              r_state <= ST_GAP;
            end else begin
              r_smp_idx  <= r_smp_idx + 3'd1;
              r_word_cnt <= '0;
              r_state    <= ST_DATA;
            end
          end
        end
        ST_GAP: begin
          r_ovlp  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data      <= '0;
      r_dvalid    <= 1'b0;
      r_last      <= 1'b0;
      r_xor       <= '0;
      r_l1a_match <= 1'b0;
      r_mlt       <= 1'b0;
      r_qovf      <= 1'b0;
    end else begin
      r_l1a_match <= bus.L1A_MATCH_IN;
      r_mlt <= (r_state != ST_IDLE) && (w_cnt >= OCC2);
      if (bus.L1A_MATCH_IN && w_full) r_qovf <= 1'b1;
      if (w_xor_clr) r_xor <= '0;
      else if (r_s1_adc) r_xor <= r_xor ^ bus.SMP_DATA;
      if (r_s1_adc) begin
        r_data   <= bus.SMP_DATA;
        r_dvalid <= 1'b1;
        r_last   <= 1'b0;
      end else if (r_s1_trl) begin
        r_data   <= r_s1_t0 ? r_xor : r_s1_word;
        r_dvalid <= 1'b1;
        r_last   <= r_s1_last;
      end else begin
        r_dvalid <= 1'b0;
        r_last   <= 1'b0;
      end
    end
  end

  assign bus.SMP_RD     = w_rd;
  assign bus.FRAME_DATA = r_data;
  assign bus.DVALID     = r_dvalid;
  assign bus.LAST_WRD   = r_last;
  assign bus.L1A_MATCH  = r_l1a_match;
  assign bus.OVLP_MUX   = r_ovlp;
  assign bus.MLT_OVLP   = r_mlt;
  assign bus.Q_OVF      = r_qovf;

endmodule
